// File: rtl/ssd_pkg.sv
// Shared seven-segment constants and decode result type.
// Used by the scan capture monitor and the display decoder.
package ssd_pkg;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_F     = 4'hF;

  // Segment order {a,b,c,d,e,f,g}, active-low
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } seg_dec_t;

  localparam seg_dec_t DEC_INVALID = '{
    valid: 1'b0,
    code:  CODE_BLANK
  };

endpackage

// File: rtl/ssd_pattern_decode.sv
// Combinational map from a 7-bit active-low segment pattern
// to {valid, code}; unknown patterns yield DEC_INVALID.
module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [6:0] pat,
  output seg_dec_t   dec
);

  always_comb begin
    dec = DEC_INVALID;
    unique case (1'b1)
      (pat == SEG_0):     dec = '{1'b1, 4'h0};
      (pat == SEG_1):     dec = '{1'b1, 4'h1};
      (pat == SEG_2):     dec = '{1'b1, 4'h2};
      (pat == SEG_3):     dec = '{1'b1, 4'h3};
      (pat == SEG_4):     dec = '{1'b1, 4'h4};
      (pat == SEG_5):     dec = '{1'b1, 4'h5};
      (pat == SEG_6):     dec = '{1'b1, 4'h6};
      (pat == SEG_7):     dec = '{1'b1, 4'h7};
      (pat == SEG_8):     dec = '{1'b1, 4'h8};
      (pat == SEG_9):     dec = '{1'b1, 4'h9};
      (pat == SEG_F):     dec = '{1'b1, CODE_F};
      (pat == SEG_BLANK): dec = '{1'b1, CODE_BLANK};
      default:            dec = DEC_INVALID;
    endcase
  end

endmodule

// File: rtl/ssd_scan_capture.sv
// Captures a multiplexed 7-seg bus back into debounced digit codes.
// Define SSD_CAPTURE_DP_EN to debounce and report decimal points.
module ssd_scan_capture
  import ssd_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int STABLE_SCANS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            display,
  input  logic [3:0]            ctrl,
  input  logic                  clr,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  update,
  output logic                  ctrl_err,
  output logic                  pat_err,
  output logic [N_DIGITS-1:0]   dp
);

  localparam int CNTW = $clog2(STABLE_SCANS + 1);
  localparam logic [CNTW-1:0] CMAX = CNTW'(STABLE_SCANS);
`ifdef SSD_CAPTURE_DP_EN
  localparam int CW = 5;
`else
  localparam int CW = 4;
`endif
  localparam logic [CW-1:0] RST_VAL = CW'(CODE_BLANK);

  seg_dec_t dec;

  ssd_pattern_decode u_dec (
    .pat (display[7:1]),
    .dec (dec)
  );

  logic [N_DIGITS-1:0] en;
  logic [2:0]          nlow;
  logic                obs;
  logic                multi;
  logic [CW-1:0]       obs_v;

  logic [CW-1:0]       cand_q [N_DIGITS];
  logic [CW-1:0]       cand_d [N_DIGITS];
  logic [CNTW-1:0]     cnt_q  [N_DIGITS];
  logic [CNTW-1:0]     cnt_d  [N_DIGITS];
  logic [CW-1:0]       val_q  [N_DIGITS];
  logic [CW-1:0]       val_d  [N_DIGITS];
  logic [N_DIGITS-1:0] valid_q, valid_d;
  logic                update_q, update_d;
  logic                ctrl_err_q, ctrl_err_d;
  logic                pat_err_q, pat_err_d;
  logic                unused_in;

  assign en = ~ctrl[N_DIGITS-1:0];
  assign unused_in = ^{display[0], ctrl};

`ifdef SSD_CAPTURE_DP_EN
  assign obs_v = {~display[0], dec.code};
`else
  assign obs_v = dec.code;
`endif

  always_comb begin
    nlow = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      nlow = nlow + 3'(en[i]);
    end
  end

  assign obs   = (nlow == 3'd1);
  assign multi = (nlow > 3'd1);

  always_comb begin
    update_d = 1'b0;
    valid_d  = valid_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      cand_d[i] = cand_q[i];
      cnt_d[i]  = cnt_q[i];
      val_d[i]  = val_q[i];
      if (obs && en[i] && dec.valid) begin
        if (obs_v == cand_q[i]) begin
          if (cnt_q[i] != CMAX) begin
            cnt_d[i] = cnt_q[i] + CNTW'(1);
          end
        end else begin
          cand_d[i] = obs_v;
          cnt_d[i]  = CNTW'(1);
        end
        // Re-commit of an unchanged value is harmless: no update.
        if (cnt_d[i] == CMAX) begin
          val_d[i]   = cand_d[i];
          valid_d[i] = 1'b1;
          if (cand_d[i] != val_q[i]) begin
            update_d = 1'b1;
          end
        end
      end
    end
    ctrl_err_d = multi | (ctrl_err_q & ~clr);
    pat_err_d  = (obs & ~dec.valid) | (pat_err_q & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        cand_q[i] <= RST_VAL;
        cnt_q[i]  <= '0;
        val_q[i]  <= RST_VAL;
      end
      valid_q    <= '0;
      update_q   <= 1'b0;
      ctrl_err_q <= 1'b0;
      pat_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        cand_q[i] <= cand_d[i];
        cnt_q[i]  <= cnt_d[i];
        val_q[i]  <= val_d[i];
      end
      valid_q    <= valid_d;
      update_q   <= update_d;
      ctrl_err_q <= ctrl_err_d;
      pat_err_q  <= pat_err_d;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_out
    assign digits[4*g +: 4] = val_q[g][3:0];
`ifdef SSD_CAPTURE_DP_EN
    assign dp[g] = val_q[g][4];
`else
    assign dp[g] = 1'b0;
`endif
  end

  assign digit_valid = valid_q;
  assign update      = update_q;
  assign ctrl_err    = ctrl_err_q;
  assign pat_err     = pat_err_q;

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Bench for ssd_scan_capture: directed table, reset sequence and
// randomized scans against a window-based reference model.
module tb_ssd_scan_capture;

  localparam int ND = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    display;
  logic [3:0]    ctrl;
  logic          clr;
  logic [15:0]   digits;
  logic [3:0]    digit_valid;
  logic          update;
  logic          ctrl_err;
  logic          pat_err;
  logic [3:0]    dp;

  int checks = 0;
  int errors = 0;

  ssd_scan_capture #(.N_DIGITS(ND), .STABLE_SCANS(SS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .display     (display),
    .ctrl        (ctrl),
    .clr         (clr),
    .digits      (digits),
    .digit_valid (digit_valid),
    .update      (update),
    .ctrl_err    (ctrl_err),
    .pat_err     (pat_err),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [7:0]  d;
    logic        k;
    logic [15:0] e_dig;
    logic [3:0]  e_val;
    logic        e_upd;
    logic        e_cerr;
    logic        e_perr;
  } vec_t;

  vec_t vt [21];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_dig,
                         input logic [3:0] e_val, input logic e_upd,
                         input logic e_cerr, input logic e_perr,
                         input logic [3:0] e_dp);
    chk({tag, ".digits"}, 32'(digits), 32'(e_dig));
    chk({tag, ".valid"}, 32'(digit_valid), 32'(e_val));
    chk({tag, ".update"}, 32'(update), 32'(e_upd));
    chk({tag, ".ctrl_err"}, 32'(ctrl_err), 32'(e_cerr));
    chk({tag, ".pat_err"}, 32'(pat_err), 32'(e_perr));
    chk({tag, ".dp"}, 32'(dp), 32'(e_dp));
  endtask

  task automatic cyc(input logic [3:0] c, input logic [7:0] d,
                     input logic k);
    ctrl = c;
    display = d;
    clr = k;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    ctrl = 4'hF;
    display = 8'hFF;
    clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference model: a digit commits whenever its last SS valid
  // observations are all the same code.
  function automatic int ref_dec(input logic [6:0] p);
    case (p)
      7'b0000001: return 0;
      7'b1001111: return 1;
      7'b0010010: return 2;
      7'b0000110: return 3;
      7'b1001100: return 4;
      7'b0100100: return 5;
      7'b0100000: return 6;
      7'b0001111: return 7;
      7'b0000000: return 8;
      7'b0000100: return 9;
      7'b0111000: return 15;
      7'b1111111: return 10;
      default:    return -1;
    endcase
  endfunction

  int         hn   [ND];
  int         hist [ND][SS];
  logic [3:0] m_dig [ND];
  logic [3:0] m_val;
  logic       m_upd, m_cerr, m_perr;

  task automatic m_reset();
    for (int i = 0; i < ND; i++) begin
      hn[i] = 0;
      m_dig[i] = 4'hA;
      for (int j = 0; j < SS; j++) hist[i][j] = 0;
    end
    m_val = '0;
    m_upd = 1'b0;
    m_cerr = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic m_step(input logic [3:0] c, input logic [7:0] d,
                        input logic k);
    int lows, dig, code;
    logic same, ne_c, ne_p;
    lows = 0;
    dig = 0;
    ne_c = 1'b0;
    ne_p = 1'b0;
    m_upd = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (!c[i]) begin
        lows++;
        dig = i;
      end
    end
    if (lows > 1) ne_c = 1'b1;
    if (lows == 1) begin
      code = ref_dec(d[7:1]);
      if (code < 0) begin
        ne_p = 1'b1;
      end else begin
        for (int j = 0; j < SS - 1; j++) hist[dig][j] = hist[dig][j+1];
        hist[dig][SS-1] = code;
        if (hn[dig] < SS) hn[dig]++;
        same = 1'b1;
        for (int j = 0; j < SS; j++)
          if (hist[dig][j] != code) same = 1'b0;
        if (hn[dig] == SS && same) begin
          if (m_dig[dig] != 4'(code)) m_upd = 1'b1;
          m_dig[dig] = 4'(code);
          m_val[dig] = 1'b1;
        end
      end
    end
    m_cerr = ne_c | (m_cerr & ~k);
    m_perr = ne_p | (m_perr & ~k);
  endtask

  logic [7:0] pool [4];

  initial begin
    logic [3:0] rc;
    logic [7:0] rd;
    logic       rk;
    int         r;

    vt[0]  = '{4'hE, 8'h25, 1'b0, 16'hAAAA, 4'h0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{4'hD, 8'h1F, 1'b0, 16'hAAAA, 4'h0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{4'hE, 8'h25, 1'b0, 16'hAAA2, 4'h1, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{4'hD, 8'h1F, 1'b0, 16'hAA72, 4'h3, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{4'hE, 8'h25, 1'b0, 16'hAA72, 4'h3, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{4'hE, 8'h0D, 1'b0, 16'hAA72, 4'h3, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{4'hE, 8'h0D, 1'b0, 16'hAA73, 4'h3, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{4'hE, 8'h49, 1'b0, 16'hAA73, 4'h3, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{4'hE, 8'h0D, 1'b0, 16'hAA73, 4'h3, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{4'hE, 8'h0D, 1'b0, 16'hAA73, 4'h3, 1'b0, 1'b0, 1'b0};
    vt[10] = '{4'hC, 8'h25, 1'b0, 16'hAA73, 4'h3, 1'b0, 1'b1, 1'b0};
    vt[11] = '{4'hF, 8'h25, 1'b1, 16'hAA73, 4'h3, 1'b0, 1'b0, 1'b0};
    vt[12] = '{4'hD, 8'h49, 1'b0, 16'hAA73, 4'h3, 1'b0, 1'b0, 1'b0};
    vt[13] = '{4'hD, 8'hFD, 1'b0, 16'hAA73, 4'h3, 1'b0, 1'b0, 1'b1};
    vt[14] = '{4'hD, 8'hFD, 1'b1, 16'hAA73, 4'h3, 1'b0, 1'b0, 1'b1};
    vt[15] = '{4'hD, 8'h49, 1'b0, 16'hAA53, 4'h3, 1'b1, 1'b0, 1'b1};
    vt[16] = '{4'hF, 8'hFF, 1'b1, 16'hAA53, 4'h3, 1'b0, 1'b0, 1'b0};
    vt[17] = '{4'hE, 8'h08, 1'b0, 16'hAA53, 4'h3, 1'b0, 1'b0, 1'b0};
    vt[18] = '{4'hE, 8'h08, 1'b0, 16'hAA59, 4'h3, 1'b1, 1'b0, 1'b0};
    vt[19] = '{4'hE, 8'h09, 1'b0, 16'hAA59, 4'h3, 1'b0, 1'b0, 1'b0};
    vt[20] = '{4'hE, 8'h08, 1'b0, 16'hAA59, 4'h3, 1'b0, 1'b0, 1'b0};

    do_reset();
    chk_all("reset", 16'hAAAA, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);

    for (int i = 0; i < 21; i++) begin
      cyc(vt[i].c, vt[i].d, vt[i].k);
      chk_all($sformatf("vec%0d", i), vt[i].e_dig, vt[i].e_val,
              vt[i].e_upd, vt[i].e_cerr, vt[i].e_perr, 4'h0);
    end

    // Async reset after one of two observations
    cyc(4'hC, 8'hFF, 1'b0);
    cyc(4'hE, 8'h0D, 1'b0);
    chk_all("pre_rst", 16'hAA59, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 16'hAAAA, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'hF, 8'hFF, 1'b0);
    chk_all("rel", 16'hAAAA, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    cyc(4'hE, 8'h0D, 1'b0);
    chk_all("rel_obs1", 16'hAAAA, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    cyc(4'hE, 8'h0D, 1'b0);
    chk_all("rel_obs2", 16'hAAA3, 4'h1, 1'b1, 1'b0, 1'b0, 4'h0);

    // Randomized scans against the reference model
    do_reset();
    m_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 0) begin
        for (int p = 0; p < 4; p++) begin
          r = $urandom_range(0, 11);
          case (r)
            0: pool[p] = 8'h03;  1: pool[p] = 8'h9F;
            2: pool[p] = 8'h25;  3: pool[p] = 8'h0D;
            4: pool[p] = 8'h99;  5: pool[p] = 8'h49;
            6: pool[p] = 8'h41;  7: pool[p] = 8'h1F;
            8: pool[p] = 8'h01;  9: pool[p] = 8'h09;
            10: pool[p] = 8'h71; default: pool[p] = 8'hFF;
          endcase
        end
      end
      r = $urandom_range(0, 9);
      if (r < 7) rc = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 7) rc = 4'hF;
      else rc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) rd = 8'($urandom_range(0, 255));
      else rd = pool[$urandom_range(0, 3)] ^ 8'($urandom_range(0, 1));
      rk = ($urandom_range(0, 15) == 0);
      ctrl = rc;
      display = rd;
      clr = rk;
      @(posedge clk);
      m_step(rc, rd, rk);
      @(negedge clk);
      chk_all($sformatf("rnd%0d", n),
              {m_dig[3], m_dig[2], m_dig[1], m_dig[0]},
              m_val, m_upd, m_cerr, m_perr, 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
